// File: rtl/mission_pkg.sv
// Shared types and helpers for the mission sequencer and its leg issuer.
package mission_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StPick,
    StRect,
    StHome,
    StDone
  } state_e;

  localparam int unsigned HomeNodeDflt = 0;

  // Index width that never collapses to zero bits for tiny parameter values.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mission_sequencer_leg_issuer.sv
// Owns the planner request registers: issues one leg, detects arrival, forces a one-cycle gap.
module leg_issuer #(
  parameter int unsigned NODE_W = 5
) (
  input  logic              clk_3125KHz,
  input  logic              rst_n,
  input  logic              run_en,
  input  logic              go,
  input  logic [NODE_W-1:0] target,
  input  logic [NODE_W-1:0] curr_node,
  output logic              path_req,
  output logic [NODE_W-1:0] path_start,
  output logic [NODE_W-1:0] path_end,
  output logic              leg_done
);

  logic              path_req_q, path_req_d;
  logic [NODE_W-1:0] path_start_q, path_start_d;
  logic [NODE_W-1:0] path_end_q, path_end_d;

  assign leg_done = run_en & path_req_q & (curr_node == path_end_q);

  always_comb begin
    path_req_d   = path_req_q;
    path_start_d = path_start_q;
    path_end_d   = path_end_q;
    if (leg_done) begin
      path_req_d = 1'b0;
    end else if (run_en && go && !path_req_q) begin
      // Only from an idle request line, so a completed leg always leaves a gap cycle.
      path_req_d   = 1'b1;
      path_start_d = curr_node;
      path_end_d   = target;
    end
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      path_req_q   <= 1'b0;
      path_start_q <= '0;
      path_end_q   <= '0;
    end else begin
      path_req_q   <= path_req_d;
      path_start_q <= path_start_d;
      path_end_q   <= path_end_d;
    end
  end

  assign path_req   = path_req_q;
  assign path_start = path_start_q;
  assign path_end   = path_end_q;

endmodule

// File: rtl/mission_sequencer.sv
// Fault-driven mission sequencer: queues unit faults, then scans, picks, rectifies and returns home.
module mission_sequencer
  import mission_pkg::*;
#(
  parameter int unsigned NODE_W    = 5,
  parameter int unsigned NUM_UNITS = 3,
  parameter int unsigned MAX_WP    = 4,
  parameter int unsigned NUM_LOC   = 4,
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned HOME_NODE = HomeNodeDflt
) (
  input  logic                                  clk_3125KHz,
  input  logic                                  rst_n,
  input  logic                                  run_en,
  input  logic [NUM_UNITS-1:0]                  fault_flag,
  input  logic                                  fault_seen,
  input  logic                                  pick_block_flag,
  input  logic [clog2_min1(NUM_LOC)-1:0]        block_location,
  input  logic [NODE_W-1:0]                     curr_node,
  input  logic [NUM_UNITS*MAX_WP*NODE_W-1:0]    wp_table,
  input  logic [NUM_UNITS*$clog2(MAX_WP+1)-1:0] wp_count,
  input  logic [NUM_LOC*NODE_W-1:0]             loc_table,
  output logic                                  path_req,
  output logic [NODE_W-1:0]                     path_start,
  output logic [NODE_W-1:0]                     path_end,
  output logic [$clog2(NUM_UNITS+1)-1:0]        fault_location,
  output logic [$clog2(MAX_WP+1)-1:0]           fault_id,
  output logic                                  all_done
);

  localparam int unsigned UnitW = clog2_min1(NUM_UNITS);
  localparam int unsigned WpcW  = $clog2(MAX_WP + 1);
  localparam int unsigned FlW   = $clog2(NUM_UNITS + 1);
  localparam logic [CNT_W-1:0]  CntMax   = '1;
  localparam logic [NODE_W-1:0] HomeNode = NODE_W'(HOME_NODE);

  state_e          state_q, state_d;
  logic [UnitW-1:0] unit_q, unit_d;
  logic [WpcW-1:0]  leg_q, leg_d;
  logic [FlW-1:0]   fault_location_q, fault_location_d;
  logic [WpcW-1:0]  fault_id_q, fault_id_d;
  logic             all_done_q, all_done_d;
  logic [CNT_W-1:0] cnt_q [NUM_UNITS];
  logic [CNT_W-1:0] cnt_d [NUM_UNITS];

  logic              any_fault;
  logic [UnitW-1:0]  first_unit;
  logic [WpcW-1:0]   wpc_raw, wpc_eff;
  logic              last_leg;
  logic [NODE_W-1:0] wp_target, loc_target, target;
  logic              go, leg_done, rect_done;

  leg_issuer #(
    .NODE_W(NODE_W)
  ) u_leg_issuer (
    .clk_3125KHz(clk_3125KHz),
    .rst_n      (rst_n),
    .run_en     (run_en),
    .go         (go),
    .target     (target),
    .curr_node  (curr_node),
    .path_req   (path_req),
    .path_start (path_start),
    .path_end   (path_end),
    .leg_done   (leg_done)
  );

  // Lowest-index unit with a pending fault wins.
  always_comb begin
    any_fault  = 1'b0;
    first_unit = '0;
    for (int u = NUM_UNITS - 1; u >= 0; u--) begin
      if (cnt_q[u] != '0) begin
        any_fault  = 1'b1;
        first_unit = UnitW'(u);
      end
    end
  end

  always_comb begin
    wpc_raw = wp_count[int'(unit_q)*WpcW +: WpcW];
    if (wpc_raw == '0) begin
      wpc_eff = WpcW'(1);
    end else if (wpc_raw > WpcW'(MAX_WP)) begin
      wpc_eff = WpcW'(MAX_WP);
    end else begin
      wpc_eff = wpc_raw;
    end
  end

  assign last_leg   = (leg_q == (wpc_eff - WpcW'(1)));
  assign wp_target  = wp_table[(int'(unit_q)*MAX_WP + int'(leg_q))*NODE_W +: NODE_W];
  assign loc_target = loc_table[int'(block_location)*NODE_W +: NODE_W];

  always_comb begin
    state_d          = state_q;
    unit_d           = unit_q;
    leg_d            = leg_q;
    fault_location_d = fault_location_q;
    fault_id_d       = fault_id_q;
    all_done_d       = all_done_q;
    go               = 1'b0;
    target           = wp_target;
    rect_done        = 1'b0;
    if (run_en) begin
      unique case (state_q)
        StIdle: begin
          if (any_fault) begin
            unit_d           = first_unit;
            fault_location_d = FlW'(first_unit) + FlW'(1);
            fault_id_d       = '0;
            leg_d            = '0;
            state_d          = StScan;
          end else begin
            state_d = StHome;
          end
        end
        StScan: begin
          go = !path_req;
          if (path_req && fault_seen && (fault_id_q == '0)) begin
            fault_id_d = leg_q + WpcW'(1);
          end
          if (leg_done) begin
            if (last_leg) begin
              leg_d   = '0;
              state_d = StPick;
            end else begin
              leg_d = leg_q + WpcW'(1);
            end
          end
        end
        StPick: begin
          target = loc_target;
          go     = !path_req && pick_block_flag;
          if (leg_done) begin
            state_d = StRect;
          end
        end
        StRect: begin
          go = !path_req;
          if (leg_done) begin
            if (last_leg) begin
              rect_done        = 1'b1;
              fault_location_d = '0;
              leg_d            = '0;
              state_d          = StIdle;
            end else begin
              leg_d = leg_q + WpcW'(1);
            end
          end
        end
        StHome: begin
          target = HomeNode;
          if (path_req) begin
            // Faults raised mid-leg wait until the bot has arrived.
            if (leg_done) begin
              state_d = StIdle;
            end
          end else if (any_fault) begin
            state_d = StIdle;
          end else if (curr_node == HomeNode) begin
            all_done_d = 1'b1;
            state_d    = StDone;
          end else begin
            go = 1'b1;
          end
        end
        StDone: begin
          if (any_fault || (|fault_flag)) begin
            all_done_d = 1'b0;
            state_d    = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Fault counters keep counting while paused; a simultaneous inc/dec cancels out.
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      cnt_d[u] = cnt_q[u];
      if (fault_flag[u] && !(rect_done && (unit_q == UnitW'(u)))) begin
        if (cnt_q[u] != CntMax) cnt_d[u] = cnt_q[u] + CNT_W'(1);
      end else if (!fault_flag[u] && rect_done && (unit_q == UnitW'(u))) begin
        if (cnt_q[u] != '0) cnt_d[u] = cnt_q[u] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      unit_q           <= '0;
      leg_q            <= '0;
      fault_location_q <= '0;
      fault_id_q       <= '0;
      all_done_q       <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) cnt_q[u] <= '0;
    end else begin
      state_q          <= state_d;
      unit_q           <= unit_d;
      leg_q            <= leg_d;
      fault_location_q <= fault_location_d;
      fault_id_q       <= fault_id_d;
      all_done_q       <= all_done_d;
      for (int u = 0; u < NUM_UNITS; u++) cnt_q[u] <= cnt_d[u];
    end
  end

  assign fault_location = fault_location_q;
  assign fault_id       = fault_id_q;
  assign all_done       = all_done_q;

endmodule

// File: tb/tb_mission_sequencer.sv
// Directed bench for mission_sequencer with a simple bot that walks to each requested node.
module tb_mission_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en;
  logic [2:0]  fault_flag;
  logic        fault_seen;
  logic        pick_block_flag;
  logic [1:0]  block_location;
  logic [4:0]  curr_node;
  logic [59:0] wp_table;
  logic [8:0]  wp_count;
  logic [19:0] loc_table;
  logic        path_req;
  logic [4:0]  path_start, path_end;
  logic [1:0]  fault_location;
  logic [2:0]  fault_id;
  logic        all_done;

  int checks = 0;
  int errors = 0;

  logic [4:0] obs_s [32];
  logic [4:0] obs_e [32];
  logic [1:0] obs_loc [32];
  logic [2:0] obs_id [32];
  logic       obs_gap [32];
  int         n_got;

  always #5 clk = ~clk;

  mission_sequencer dut (
    .clk_3125KHz    (clk),
    .rst_n          (rst_n),
    .run_en         (run_en),
    .fault_flag     (fault_flag),
    .fault_seen     (fault_seen),
    .pick_block_flag(pick_block_flag),
    .block_location (block_location),
    .curr_node      (curr_node),
    .wp_table       (wp_table),
    .wp_count       (wp_count),
    .loc_table      (loc_table),
    .path_req       (path_req),
    .path_start     (path_start),
    .path_end       (path_end),
    .fault_location (fault_location),
    .fault_id       (fault_id),
    .all_done       (all_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (path_req === 1'b1) begin
        timed_out = 1'b0;
        return;
      end
      tick();
    end
  endtask

  // Bot model: follow n legs, recording what the DUT asked for; no checking here.
  task automatic drive_legs(input int n, input int seen_leg, input int inj_leg,
                            input logic [2:0] inj);
    bit to;
    n_got = 0;
    for (int i = 0; i < n; i++) begin
      wait_req(to);
      if (to) return;
      obs_s[i]   = path_start;
      obs_e[i]   = path_end;
      obs_loc[i] = fault_location;
      obs_id[i]  = fault_id;
      n_got      = i + 1;
      if (i == seen_leg) begin
        fault_seen = 1'b1;
        tick();
        fault_seen = 1'b0;
      end
      curr_node = path_end;
      if (i == inj_leg) fault_flag = inj;
      tick();
      fault_flag = '0;
      obs_gap[i] = ~path_req;
    end
  endtask

  task automatic pulse_fault(input logic [2:0] f);
    fault_flag = f;
    tick();
    fault_flag = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (path_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", path_req); end
    checks++; if (path_start !== 5'd0) begin errors++; $display("FAIL reset_start got %0d want 0", path_start); end
    checks++; if (path_end !== 5'd0) begin errors++; $display("FAIL reset_end got %0d want 0", path_end); end
    checks++; if (fault_location !== 2'd0) begin errors++; $display("FAIL reset_loc got %0d want 0", fault_location); end
    checks++; if (fault_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d want 0", fault_id); end
    checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", all_done); end
  endtask

  task automatic test_idle_home();
    bit saw_req = 1'b0;
    bit done    = 1'b0;
    curr_node = 5'd0;
    #20 rst_n = 1'b1;
    for (int c = 0; c < 3 && !done; c++) begin
      tick();
      if (path_req) saw_req = 1'b1;
      if (all_done) done = 1'b1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL idle_home_done got %b want 1", done); end
    checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL idle_home_noleg got %b want 0", saw_req); end
  endtask

  task automatic test_single_eu();
    int es [8] = '{1, 29, 27, 24, 22, 29, 27, 24};
    int ee [8] = '{29, 27, 24, 22, 29, 27, 24, 0};
    int el [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int ei [8] = '{0, 0, 2, 2, 2, 2, 2, 2};
    bit done = 1'b0;
    curr_node = 5'd1;
    pick_block_flag = 1'b1;
    block_location = 2'd0;
    tick();
    pulse_fault(3'b001);
    checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL eu_done_clear got %b want 0", all_done); end
    tick();
    checks++; if (path_req !== 1'b0) begin errors++; $display("FAIL eu_latency_early got %b want 0", path_req); end
    tick();
    checks++; if (path_req !== 1'b1) begin errors++; $display("FAIL eu_latency got %b want 1", path_req); end
    drive_legs(8, 1, -1, 3'b000);
    checks++; if (n_got != 8) begin errors++; $display("FAIL eu_leg_count got %0d want 8", n_got); end
    for (int i = 0; i < n_got; i++) begin
      checks++;
      if (obs_s[i] != es[i] || obs_e[i] != ee[i] || obs_loc[i] != el[i] || obs_id[i] != ei[i]
          || obs_gap[i] !== 1'b1) begin
        errors++;
        $display("FAIL eu_leg%0d got %0d->%0d loc %0d id %0d gap %b want %0d->%0d loc %0d id %0d gap 1",
                 i, obs_s[i], obs_e[i], obs_loc[i], obs_id[i], obs_gap[i], es[i], ee[i], el[i], ei[i]);
      end
    end
    for (int c = 0; c < 5 && !done; c++) begin
      if (all_done) done = 1'b1;
      else tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL eu_all_done got %b want 1", done); end
  endtask

  task automatic test_two_units();
    int es [17] = '{0, 7, 5, 2, 22, 7, 5, 2, 19, 17, 15, 12, 22, 19, 17, 15, 12};
    int ee [17] = '{7, 5, 2, 22, 7, 5, 2, 19, 17, 15, 12, 22, 19, 17, 15, 12, 0};
    int el [17] = '{2, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 0};
    bit done = 1'b0;
    pulse_fault(3'b110);
    drive_legs(17, -1, -1, 3'b000);
    checks++; if (n_got != 17) begin errors++; $display("FAIL two_leg_count got %0d want 17", n_got); end
    for (int i = 0; i < n_got; i++) begin
      checks++;
      if (obs_s[i] != es[i] || obs_e[i] != ee[i] || obs_loc[i] != el[i] || obs_id[i] != 3'd0) begin
        errors++;
        $display("FAIL two_leg%0d got %0d->%0d loc %0d id %0d want %0d->%0d loc %0d id 0",
                 i, obs_s[i], obs_e[i], obs_loc[i], obs_id[i], es[i], ee[i], el[i]);
      end
    end
    for (int c = 0; c < 5 && !done; c++) begin
      if (all_done) done = 1'b1;
      else tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL two_all_done got %b want 1", done); end
  endtask

  task automatic test_inc_dec_and_sat();
    int es [15] = '{0, 29, 27, 24, 22, 29, 27, 24, 29, 27, 24, 22, 29, 27, 24};
    int ee [15] = '{29, 27, 24, 22, 29, 27, 24, 29, 27, 24, 22, 29, 27, 24, 0};
    int exp_s, exp_e, prev;
    pulse_fault(3'b001);
    drive_legs(15, -1, 6, 3'b001);
    checks++; if (n_got != 15) begin errors++; $display("FAIL incdec_leg_count got %0d want 15", n_got); end
    for (int i = 0; i < n_got; i++) begin
      checks++;
      if (obs_s[i] != es[i] || obs_e[i] != ee[i] || obs_loc[i] != ((i < 14) ? 2'd1 : 2'd0)) begin
        errors++;
        $display("FAIL incdec_leg%0d got %0d->%0d loc %0d want %0d->%0d",
                 i, obs_s[i], obs_e[i], obs_loc[i], es[i], ee[i]);
      end
    end
    // EU with zero legs configured behaves as one leg; eight faults saturate at seven services.
    wp_count[2:0] = 3'd0;
    while (!all_done) tick();
    for (int p = 0; p < 8; p++) begin
      fault_flag = 3'b001;
      tick();
    end
    fault_flag = '0;
    drive_legs(22, -1, -1, 3'b000);
    checks++; if (n_got != 22) begin errors++; $display("FAIL sat_leg_count got %0d want 22", n_got); end
    prev = 0;
    for (int i = 0; i < n_got; i++) begin
      exp_s = prev;
      exp_e = (i == 21) ? 0 : ((i % 3 == 1) ? 22 : 29);
      prev  = exp_e;
      checks++;
      if (obs_s[i] != exp_s || obs_e[i] != exp_e) begin
        errors++;
        $display("FAIL sat_leg%0d got %0d->%0d want %0d->%0d", i, obs_s[i], obs_e[i], exp_s, exp_e);
      end
    end
    wp_count[2:0] = 3'd3;
    for (int c = 0; c < 5 && !all_done; c++) tick();
  endtask

  task automatic test_pause_and_reset();
    bit to;
    bit done = 1'b0;
    bit saw_req = 1'b0;
    pulse_fault(3'b001);
    wait_req(to);
    checks++; if (to) begin errors++; $display("FAIL pause_issue got timeout want path_req"); end
    run_en = 1'b0;
    curr_node = path_end;
    repeat (3) tick();
    checks++; if (path_req !== 1'b1) begin errors++; $display("FAIL pause_hold_req got %b want 1", path_req); end
    checks++; if (path_end !== 5'd29) begin errors++; $display("FAIL pause_hold_end got %0d want 29", path_end); end
    checks++; if (fault_location !== 2'd1) begin errors++; $display("FAIL pause_hold_loc got %0d want 1", fault_location); end
    run_en = 1'b1;
    tick();
    checks++; if (path_req !== 1'b0) begin errors++; $display("FAIL pause_gap got %b want 0", path_req); end
    tick();
    checks++;
    if (path_req !== 1'b1 || path_start !== 5'd29 || path_end !== 5'd27) begin
      errors++;
      $display("FAIL pause_next got req %b %0d->%0d want req 1 29->27", path_req, path_start, path_end);
    end
    drive_legs(3, -1, -1, 3'b000);
    wait_req(to);
    checks++;
    if (to || path_start !== 5'd22 || path_end !== 5'd29 || fault_location !== 2'd1) begin
      errors++;
      $display("FAIL rect_leg got %0d->%0d loc %0d want 22->29 loc 1", path_start, path_end, fault_location);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (path_req !== 1'b0 || path_start !== 5'd0 || path_end !== 5'd0 || fault_location !== 2'd0 ||
        fault_id !== 3'd0 || all_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got req %b %0d->%0d loc %0d id %0d done %b want all 0",
               path_req, path_start, path_end, fault_location, fault_id, all_done);
    end
    curr_node = 5'd0;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4 && !done; c++) begin
      tick();
      if (path_req) saw_req = 1'b1;
      if (all_done) done = 1'b1;
    end
    checks++;
    if (done !== 1'b1 || saw_req !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got done %b req %b want done 1 req 0", done, saw_req);
    end
  endtask

  initial begin
    run_en = 1'b1;
    fault_flag = '0;
    fault_seen = 1'b0;
    pick_block_flag = 1'b0;
    block_location = '0;
    curr_node = '0;
    wp_table = '0;
    wp_table[0*5 +: 5]  = 5'd29; wp_table[1*5 +: 5]  = 5'd27; wp_table[2*5 +: 5]  = 5'd24;
    wp_table[4*5 +: 5]  = 5'd7;  wp_table[5*5 +: 5]  = 5'd5;  wp_table[6*5 +: 5]  = 5'd2;
    wp_table[8*5 +: 5]  = 5'd19; wp_table[9*5 +: 5]  = 5'd17; wp_table[10*5 +: 5] = 5'd15;
    wp_table[11*5 +: 5] = 5'd12;
    wp_count = {3'd4, 3'd3, 3'd3};
    loc_table = {5'd11, 5'd23, 5'd10, 5'd22};
    test_reset();
    test_idle_home();
    test_single_eu();
    test_two_units();
    test_inc_dec_and_sat();
    test_pause_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
